// File: rtl/mem_cmd_issuer_if.sv
// mem_cmd_issuer_if: host command channel plus memory-controller command bus.
// master = host/controller side, slave = the issuer.
interface mem_cmd_issuer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [16:0] cmd_addr;
    logic [2:0]  cmd_zoom;
    logic        mc_enable;
    logic [2:0]  mc_operation;
    logic [16:0] mc_addr_base;
    logic [2:0]  mc_zoom;
    logic        mc_done;
    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_zoom, mc_done,
        input  cmd_ready, mc_enable, mc_operation, mc_addr_base, mc_zoom
    );
    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_zoom, mc_done,
        output cmd_ready, mc_enable, mc_operation, mc_addr_base, mc_zoom
    );
endinterface

// File: rtl/mem_cmd_issuer.sv
// mem_cmd_issuer: queues host memory commands and issues them one at a time to a memory controller.
// Define MEM_CMD_ISSUER_TIMEOUT_EN to build the WAIT-state watchdog.
module mem_cmd_issuer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic            clock,
    input  logic            reset_n,
    mem_cmd_issuer_if.slave bus,
    input  logic            err_clear,
    output logic            cmd_done,
    output logic            busy,
    output logic [4:0]      queue_level,
    output logic            err_invalid,
    output logic            err_timeout
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;
    state_t state, state_nxt;
    logic [22:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic accept, push, pop, tout;
    assign bus.cmd_ready = queue_level != 5'(FIFO_DEPTH);
    assign accept = bus.cmd_valid && bus.cmd_ready;
    assign push = accept && bus.cmd_op != 3'b000 && bus.cmd_op != 3'b111;
    assign busy = state != IDLE || queue_level != 5'd0;
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= {bus.cmd_op, bus.cmd_addr, bus.cmd_zoom};
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else state <= state_nxt;
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            queue_level      <= '0;
            bus.mc_operation <= '0;
            bus.mc_addr_base <= '0;
            bus.mc_zoom      <= '0;
            err_invalid      <= 1'b0;
        end else begin
            wr_ptr      <= wr_ptr + AW'(push);
            rd_ptr      <= rd_ptr + AW'(pop);
            queue_level <= queue_level + 5'(push) - 5'(pop);
            if (pop) {bus.mc_operation, bus.mc_addr_base, bus.mc_zoom} <= mem[rd_ptr];
            err_invalid <= (accept && !push) || (err_invalid && !err_clear);
        end
    end
    always_comb begin
        state_nxt     = state;
        pop           = 1'b0;
        bus.mc_enable = 1'b0;
        cmd_done      = 1'b0;
        case (state)
            IDLE: if (queue_level != 5'd0 && bus.mc_done) begin
                pop       = 1'b1;
                state_nxt = ISSUE;
            end
            ISSUE: begin
                bus.mc_enable = 1'b1;
                state_nxt     = WAIT_ACK;
            end
            WAIT_ACK: if (!bus.mc_done) state_nxt = WAIT_DONE;
            WAIT_DONE: if (bus.mc_done) begin
                cmd_done  = 1'b1;
                state_nxt = IDLE;
            end
        endcase
        if (tout) begin
            state_nxt = IDLE;
            cmd_done  = 1'b0;
        end
    end
`ifdef MEM_CMD_ISSUER_TIMEOUT_EN
    logic [15:0] wd_cnt;
    logic waiting;
    assign waiting = state == WAIT_ACK || state == WAIT_DONE;
    // budget covers both wait states together, fires on the TIMEOUT_CYCLES-th waiting cycle
    assign tout = waiting && wd_cnt == 16'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt      <= '0;
            err_timeout <= 1'b0;
        end else begin
            wd_cnt      <= (waiting && !tout) ? wd_cnt + 16'd1 : 16'd0;
            err_timeout <= tout || (err_timeout && !err_clear);
        end
    end
`else
    assign tout = 1'b0;
    // watchdog compiled out; the parameter stays referenced so both builds share one interface
    assign err_timeout = TIMEOUT_CYCLES < 0;
`endif
endmodule

// File: doc/mem_cmd_issuer.md
MEM_CMD_ISSUER -- requirements
Module: mem_cmd_issuer

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; no other clock or reset inputs.
REQ-002 Parameter FIFO_DEPTH, default 4, SHALL set command queue depth (power of two, 2..16).
REQ-003 Parameter TIMEOUT_CYCLES, default 1024, SHALL set the watchdog limit in clock cycles (16-bit).
REQ-004 Port list:
- clock  in  1  rising-edge clock
- reset_n  in  1  async active-low reset
- cmd_valid  in  1  host offers a command
- cmd_ready  out  1  queue can accept
- cmd_op  in  3  operation code
- cmd_addr  in  17  base address
- cmd_zoom  in  3  zoom level
- err_clear  in  1  clears sticky error flags
- mc_enable  out  1  start pulse to memory controller
- mc_operation  out  3  operation to controller
- mc_addr_base  out  17  base address to controller
- mc_zoom  out  3  zoom to controller
- mc_done  in  1  controller done/idle level
- cmd_done  out  1  one-cycle completion pulse
- busy  out  1  command in flight or queue non-empty
- queue_level  out  5  current queue occupancy
- err_invalid  out  1  sticky: illegal opcode dropped
- err_timeout  out  1  sticky: watchdog fired

Function
REQ-005 Command SHALL be accepted on a rising edge with cmd_valid=1 and cmd_ready=1; {op,addr,zoom} SHALL be written into a FIFO_DEPTH-deep FIFO.
REQ-006 cmd_ready SHALL be 0 exactly when queue_level==FIFO_DEPTH; with the queue full, cmd_valid SHALL be ignored and no data lost or overwritten.
REQ-007 Legal opcodes are 001..110; opcodes 000 and 111 SHALL be dropped at acceptance (not queued) and SHALL set err_invalid.
REQ-008 FSM states: IDLE, ISSUE, WAIT_ACK, WAIT_DONE.
REQ-009 IDLE: queue non-empty and mc_done==1 -> pop head, load mc_operation/mc_addr_base/mc_zoom, go ISSUE; otherwise stay.
REQ-010 ISSUE: mc_enable SHALL be 1 for exactly this one cycle; next state WAIT_ACK.
REQ-011 WAIT_ACK: mc_done==0 -> WAIT_DONE; else stay.
REQ-012 WAIT_DONE: mc_done==1 -> assert cmd_done for one cycle, go IDLE.
REQ-013 Latency: command accepted at edge N into an empty queue with FSM in IDLE and mc_done=1 SHALL see mc_enable=1 from edge N+1 to edge N+2.
REQ-014 mc_operation/mc_addr_base/mc_zoom SHALL hold stable from ISSUE until the next pop.
REQ-015 Simultaneous push and pop SHALL leave queue_level unchanged; both pointers wrap modulo FIFO_DEPTH.
REQ-016 busy SHALL be 1 when FSM is not IDLE or queue_level>0.
REQ-017 err_clear SHALL zero both sticky flags; a setting event in the same cycle SHALL win.

Reset
REQ-018 reset_n=0 SHALL immediately force: FSM IDLE, queue empty, queue_level=0, cmd_ready=1, mc_enable=0, mc_operation=0, mc_addr_base=0, mc_zoom=0, cmd_done=0, busy=0, err_invalid=0, err_timeout=0.
REQ-019 Reset during ISSUE/WAIT_* SHALL abandon the in-flight command and all queued commands without a cmd_done pulse.

Configuration
REQ-020 Macro MEM_CMD_ISSUER_TIMEOUT_EN defined: a 16-bit counter SHALL run in WAIT_ACK/WAIT_DONE; reaching TIMEOUT_CYCLES SHALL set err_timeout, return FSM to IDLE, and suppress cmd_done for that command.
REQ-021 Macro undefined: no counter is built, err_timeout SHALL be constant 0, and WAIT states SHALL wait indefinitely.

Verification
REQ-022 Single cmd op=001 addr=0x00100 zoom=2, controller model drops done 1 cycle after enable and raises it 5 cycles later -> one mc_enable pulse with mc_addr_base=0x00100, one cmd_done, busy returns to 0.
REQ-023 Push 5 commands back-to-back with mc_done held 0 -> cmd_ready=0 after 4th, queue_level=4, 5th held until a pop; order preserved on mc_operation.
REQ-024 cmd_op=111 then cmd_op=000 -> neither queued, err_invalid=1, queue_level=0; err_clear pulse -> err_invalid=0.
REQ-025 With MEM_CMD_ISSUER_TIMEOUT_EN, TIMEOUT_CYCLES=16, mc_done stuck 1 after enable -> err_timeout=1 at 16 cycles, FSM IDLE, no cmd_done.
REQ-026 reset_n=0 during WAIT_DONE with 2 queued -> all outputs at reset values same cycle, queue_level=0, no cmd_done after release.
